// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : MEM-stage controller splitting 32-bit loads/stores into two
//            16-bit SRAM accesses, freezing the pipeline while busy.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] alu_result,
  input  logic [31:0] ST_val,
  output logic        ready,
  output logic [31:0] mem_rdata,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_WE_N
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] C_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] wa_q, wa_d;
  logic [31:0] st_q, st_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        w_req;
  logic [16:0] w_wa;
  logic        w_unused;

  assign w_req = MEM_R_EN | MEM_W_EN;
  // (a - 1024) >> 2 truncated to 17 bits equals a[18:2] - 256 modulo 2^17
  assign w_wa  = alu_result[18:2] - 17'd256;
  assign w_unused = &{alu_result[31:19], alu_result[1:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wa_q    <= 17'd0;
      st_q    <= 32'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      st_q    <= st_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    st_d    = st_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          wa_d    = w_wa;
          st_d    = ST_val;
          wr_d    = MEM_W_EN;
          cnt_d   = 4'd0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_HIGH;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    SRAM_ADDR   = 18'd0;
    SRAM_DQ_out = 16'd0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    case (state_q)
      S_IDLE: ready = ~w_req;
      S_LOW: begin
        SRAM_ADDR = {wa_q, 1'b0};
        if (wr_q) begin
          SRAM_WE_N   = 1'b0;
          SRAM_DQ_oe  = 1'b1;
          SRAM_DQ_out = st_q[15:0];
        end
      end
      S_HIGH: begin
        SRAM_ADDR = {wa_q, 1'b1};
        if (wr_q) begin
          SRAM_WE_N   = 1'b0;
          SRAM_DQ_oe  = 1'b1;
          SRAM_DQ_out = st_q[31:16];
        end
      end
      default: ready = 1'b1;
    endcase
    if (rst) ready = 1'b1;
  end

  assign mem_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Scoreboard bench for mem_access_ctrl (W=2 and W=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        r_en0, w_en0, r_en1, w_en1;
  logic [31:0] alu0, st0, alu1, st1;
  logic        ready0, ready1, oe0, oe1, we_n0, we_n1;
  logic [31:0] rdata0, rdata1;
  logic [17:0] addr0, addr1;
  logic [15:0] dq_out0, dq_out1, dq_in0, dq_in1;

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];

  mem_access_ctrl #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en0), .MEM_W_EN(w_en0),
    .alu_result(alu0), .ST_val(st0), .ready(ready0), .mem_rdata(rdata0),
    .SRAM_ADDR(addr0), .SRAM_DQ_out(dq_out0), .SRAM_DQ_oe(oe0),
    .SRAM_DQ_in(dq_in0), .SRAM_WE_N(we_n0)
  );

  mem_access_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en1), .MEM_W_EN(w_en1),
    .alu_result(alu1), .ST_val(st1), .ready(ready1), .mem_rdata(rdata1),
    .SRAM_ADDR(addr1), .SRAM_DQ_out(dq_out1), .SRAM_DQ_oe(oe1),
    .SRAM_DQ_in(dq_in1), .SRAM_WE_N(we_n1)
  );

  // Behavioural SRAMs: asynchronous read, write on the edge while WE_N low
  assign dq_in0 = mem0[addr0[5:0]];
  assign dq_in1 = mem1[addr1[5:0]];
  always @(posedge clk) begin
    if (!we_n0) mem0[addr0[5:0]] <= dq_out0;
    if (!we_n1) mem1[addr1[5:0]] <= dq_out1;
  end

  typedef struct {
    int          dut;
    string       nm;
    logic        ready;
    logic        we_n;
    logic        oe;
    logic [17:0] addr;
    logic [15:0] dq;
    logic [31:0] rdata;
    bit          chk_rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every negedge, compare whatever the stimulus queued for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          chk({e.nm, ".ready"}, 32'(ready0), 32'(e.ready));
          chk({e.nm, ".we_n"},  32'(we_n0),  32'(e.we_n));
          chk({e.nm, ".oe"},    32'(oe0),    32'(e.oe));
          chk({e.nm, ".addr"},  32'(addr0),  32'(e.addr));
          chk({e.nm, ".dq"},    32'(dq_out0), 32'(e.dq));
          if (e.chk_rd) chk({e.nm, ".rdata"}, rdata0, e.rdata);
        end else begin
          chk({e.nm, ".ready"}, 32'(ready1), 32'(e.ready));
          chk({e.nm, ".we_n"},  32'(we_n1),  32'(e.we_n));
          chk({e.nm, ".oe"},    32'(oe1),    32'(e.oe));
          chk({e.nm, ".addr"},  32'(addr1),  32'(e.addr));
          chk({e.nm, ".dq"},    32'(dq_out1), 32'(e.dq));
          if (e.chk_rd) chk({e.nm, ".rdata"}, rdata1, e.rdata);
        end
      end
    end
  end

  task automatic push(int d, string nm, logic rdy, logic we_n, logic oe,
                      logic [17:0] addr, logic [15:0] dq, logic [31:0] rd, bit chk_rd);
    exp_t e;
    e.dut = d; e.nm = nm; e.ready = rdy; e.we_n = we_n; e.oe = oe;
    e.addr = addr; e.dq = dq; e.rdata = rd; e.chk_rd = chk_rd;
    exp_q.push_back(e);
  endtask

  task automatic drive(int d, logic rd, logic wr, logic [31:0] a, logic [31:0] s);
    if (d == 0) begin
      r_en0 = rd; w_en0 = wr; alu0 = a; st0 = s;
    end else begin
      r_en1 = rd; w_en1 = wr; alu1 = a; st1 = s;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full access: IDLE request cycle, 2*W busy cycles, one DONE cycle
  task automatic access(int d, string nm, logic rd, logic wr, logic [31:0] a,
                        logic [31:0] s, int w, logic [31:0] rd_prev, logic [31:0] rd_done,
                        logic [16:0] wa);
    drive(d, rd, wr, a, s);
    push(d, {nm, "_c0"}, 1'b0, 1'b1, 1'b0, 18'd0, 16'd0, rd_prev, 1'b1);
    next_cycle();
    for (int k = 0; k < 2 * w; k++) begin
      bit hi;
      hi = (k >= w);
      // inputs wander while busy; only the latched copy may matter
      drive(d, 1'($urandom), 1'($urandom), $urandom, $urandom);
      push(d, $sformatf("%s_c%0d", nm, k + 1), 1'b0, ~wr, wr, {wa, hi},
           wr ? (hi ? s[31:16] : s[15:0]) : 16'd0, 32'd0, 1'b0);
      next_cycle();
    end
    drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
    push(d, {nm, "_done"}, 1'b1, 1'b1, 1'b0, 18'd0, 16'd0, rd_done, 1'b1);
    next_cycle();
  endtask

  task automatic idle(int d, string nm, int n, logic [31:0] rd);
    drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < n; k++) begin
      push(d, nm, 1'b1, 1'b1, 1'b0, 18'd0, 16'd0, rd, 1'b1);
      next_cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    mem0[0] = 16'h1111;
    mem0[1] = 16'h2222;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();

    // Reset state on both instances
    for (int k = 0; k < 2; k++) begin
      push(0, "reset0", 1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0, 1'b1);
      push(1, "reset1", 1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0, 1'b1);
      next_cycle();
    end
    rst = 1'b0;

    idle(0, "idle", 10, 32'd0);

    access(0, "store1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 2,
           32'd0, 32'd0, 17'd1);
    access(0, "load1028", 1'b1, 1'b0, 32'd1028, 32'h0, 2,
           32'd0, 32'hDEADBEEF, 17'd1);
    idle(0, "gap", 2, 32'hDEADBEEF);

    // Back-to-back: only the DONE cycle of the load shows ready high
    access(0, "b2b_load1024", 1'b1, 1'b0, 32'd1024, 32'h0, 2,
           32'hDEADBEEF, 32'h22221111, 17'd0);
    access(0, "b2b_store1032", 1'b0, 1'b1, 32'd1032, 32'h12345678, 2,
           32'h22221111, 32'h22221111, 17'd2);
    access(0, "load1032", 1'b1, 1'b0, 32'd1032, 32'h0, 2,
           32'h22221111, 32'h12345678, 17'd2);

    // Reset during the HIGH half of a load
    drive(0, 1'b1, 1'b0, 32'd1028, 32'h0);
    push(0, "rstmid_c0", 1'b0, 1'b1, 1'b0, 18'd0, 16'd0, 32'h12345678, 1'b1);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      push(0, "rstmid_low", 1'b0, 1'b1, 1'b0, 18'd2, 16'd0, 32'd0, 1'b0);
      next_cycle();
    end
    rst = 1'b1;
    push(0, "rstmid_high", 1'b1, 1'b1, 1'b0, 18'd3, 16'd0, 32'd0, 1'b0);
    next_cycle();
    push(0, "rstmid_after", 1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0, 1'b1);
    next_cycle();
    rst = 1'b0;
    idle(0, "rstmid_idle", 3, 32'd0);

    // Both enables with W=1: treated as a write, 3 stall cycles
    access(1, "both1036", 1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 1,
           32'd0, 32'd0, 17'd3);
    access(1, "load1036", 1'b1, 1'b0, 32'd1036, 32'h0, 1,
           32'd0, 32'hCAFEF00D, 17'd3);
    idle(1, "idle1", 2, 32'hCAFEF00D);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
